inst_test_sequencer: RTL and testbench

Synthesizable run-and-check controller for the OpenMIPS core. It holds the core in reset for a programmable number of cycles, then lets it run for a fixed cycle budget. It then reads a list of architectural registers through the register file's debug read port and compares each against an expected value, reporting pass or first failure. It sits beside `top`, driving the core's reset and the regfile debug port, so instruction tests self-check in simulation or on FPGA without waveform inspection.

---
 rtl/inst_test_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_inst_test_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inst_test_sequencer
// Purpose  : Run-and-check controller for the OpenMIPS core. Holds the core in
//            reset, lets it run for a cycle budget, then compares a table of
//            architectural registers (via the regfile debug port) against
//            expected values and reports pass or the first failing entry.
// Options  : TEST_SEQ_HALT_EN adds i_halt_req / o_run_count (early RUN exit).
// Revision : 1.0 - initial release
// ============================================================================
module inst_test_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IDX_WIDTH      = 2,
  parameter int NUM_CHECKS     = 4,
  parameter int RESET_CYCLES   = 10,
  parameter int RUN_CYCLES     = 100,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_exp_we,
  input  logic [IDX_WIDTH-1:0]      i_exp_idx,
  input  logic [REG_ADDR_WIDTH-1:0] i_exp_addr,
  input  logic [DATA_WIDTH-1:0]     i_exp_data,
  output logic                      o_core_rst,
  output logic [REG_ADDR_WIDTH-1:0] o_dbg_raddr,
  input  logic [DATA_WIDTH-1:0]     i_dbg_rdata,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [IDX_WIDTH-1:0]      o_fail_idx,
  output logic [DATA_WIDTH-1:0]     o_fail_data
`ifdef TEST_SEQ_HALT_EN
  ,
  input  logic                      i_halt_req,
  output logic [CNT_WIDTH-1:0]      o_run_count
`endif
);

  localparam int                   c_TBL_DEPTH  = 2 ** IDX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_RST_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_RUN_LAST   = CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] c_CHK_LAST   = IDX_WIDTH'(NUM_CHECKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [IDX_WIDTH-1:0]        r_idx;
  logic                        r_pass;
  logic [IDX_WIDTH-1:0]        r_fail_idx;
  logic [DATA_WIDTH-1:0]       r_fail_data;
  logic [REG_ADDR_WIDTH-1:0]   r_tbl_addr [c_TBL_DEPTH];
  logic [DATA_WIDTH-1:0]       r_tbl_data [c_TBL_DEPTH];

  logic                        w_busy;
  logic                        w_launch;
  logic                        w_match;
  logic                        w_halt;
  logic                        w_core_rst;
  logic [REG_ADDR_WIDTH-1:0]   w_raddr;

`ifdef TEST_SEQ_HALT_EN
  logic [CNT_WIDTH-1:0]        r_run_count;
  assign w_halt      = i_halt_req;
  assign o_run_count = r_run_count;
`else
  assign w_halt      = 1'b0;
`endif

  // Debug read data is combinational from the address, so compare in-cycle.
  assign w_match  = (i_dbg_rdata == r_tbl_data[r_idx]);
  // A start is only honoured when no run is in progress.
  assign w_launch = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_core_rst   = 1'b0;
    w_raddr      = '0;
    case (r_state)
      S_IDLE: begin
        w_core_rst = 1'b1;
        if (i_start) w_state_next = S_RESET;
      end
      S_RESET: begin
        w_core_rst = 1'b1;
        w_busy     = 1'b1;
        if (r_cnt == c_RST_LAST) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if ((r_cnt == c_RUN_LAST) || w_halt) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        w_busy  = 1'b1;
        w_raddr = r_tbl_addr[r_idx];
        if (!w_match || (r_idx == c_CHK_LAST)) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (i_start) w_state_next = S_RESET;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Check table: writable only while no run is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_TBL_DEPTH; i++) begin
        r_tbl_addr[i] <= '0;
        r_tbl_data[i] <= '0;
      end
    end else if (i_exp_we && !w_busy) begin
      r_tbl_addr[i_exp_idx] <= i_exp_addr;
      r_tbl_data[i_exp_idx] <= i_exp_data;
    end
  end

  // Phase counter, check index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pass      <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_data <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_cnt       <= '0;
            r_pass      <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_data <= '0;
          end
        end
        S_RESET: begin
          r_cnt <= (r_cnt == c_RST_LAST) ? '0 : r_cnt + 1'b1;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_idx <= '0;
        end
        S_CHECK: begin
          if (!w_match) begin
            r_fail_idx  <= r_idx;
            r_fail_data <= i_dbg_rdata;
            r_pass      <= 1'b0;
          end else if (r_idx == c_CHK_LAST) begin
            r_pass <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TEST_SEQ_HALT_EN
  // Number of RUN cycles executed in the current run, halting cycle included.
  always_ff @(posedge clk) begin
    if (rst || w_launch)        r_run_count <= '0;
    else if (r_state == S_RUN)  r_run_count <= r_run_count + 1'b1;
  end
`endif

  assign o_core_rst  = w_core_rst;
  assign o_dbg_raddr = w_raddr;
  assign o_busy      = w_busy;
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = r_pass;
  assign o_fail_idx  = r_fail_idx;
  assign o_fail_data = r_fail_data;

endmodule
`default_nettype wire

// File: tb/tb_inst_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_inst_test_sequencer
// Purpose  : Directed self-checking bench for inst_test_sequencer with a
//            fixed register-file image standing in for the core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_test_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_exp_we;
  logic [1:0]  i_exp_idx;
  logic [4:0]  i_exp_addr;
  logic [31:0] i_exp_data;
  logic        o_core_rst;
  logic [4:0]  o_dbg_raddr;
  logic [31:0] i_dbg_rdata;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [1:0]  o_fail_idx;
  logic [31:0] o_fail_data;
`ifdef TEST_SEQ_HALT_EN
  logic        i_halt_req;
  logic [15:0] o_run_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  inst_test_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_exp_we    (i_exp_we),
    .i_exp_idx   (i_exp_idx),
    .i_exp_addr  (i_exp_addr),
    .i_exp_data  (i_exp_data),
    .o_core_rst  (o_core_rst),
    .o_dbg_raddr (o_dbg_raddr),
    .i_dbg_rdata (i_dbg_rdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_fail_idx  (o_fail_idx),
    .o_fail_data (o_fail_data)
`ifdef TEST_SEQ_HALT_EN
    ,
    .i_halt_req  (i_halt_req),
    .o_run_count (o_run_count)
`endif
  );

  // Register image left by the logic-instruction program.
  always_comb begin
    case (o_dbg_raddr)
      5'd1:    i_dbg_rdata = 32'h0101_0000;
      5'd2:    i_dbg_rdata = 32'h0101_1101;
      5'd3:    i_dbg_rdata = 32'h0000_0000;
      5'd4:    i_dbg_rdata = 32'h0000_1100;
      default: i_dbg_rdata = 32'h0000_0000;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [4:0] addr, input logic [31:0] data);
    i_exp_we   = 1'b1;
    i_exp_idx  = idx;
    i_exp_addr = addr;
    i_exp_data = data;
    tick();
    i_exp_we   = 1'b0;
  endtask

  // Pulse start at cycle 0; afterwards cyc counts from 1.
  task automatic launch();
    cyc     = 0;
    i_start = 1'b1;
    tick();
    i_start  = 1'b0;
    i_exp_we = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    i_start    = 1'b0;
    i_exp_we   = 1'b0;
    i_exp_idx  = '0;
    i_exp_addr = '0;
    i_exp_data = '0;
`ifdef TEST_SEQ_HALT_EN
    i_halt_req = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_core_rst",  32'(o_core_rst),  32'd1);
    chk("rst_busy",      32'(o_busy),      32'd0);
    chk("rst_done",      32'(o_done),      32'd0);
    chk("rst_pass",      32'(o_pass),      32'd0);
    chk("rst_fail_idx",  32'(o_fail_idx),  32'd0);
    chk("rst_fail_data", o_fail_data,      32'd0);
    chk("rst_raddr",     32'(o_dbg_raddr), 32'd0);

    wr(2'd0, 5'd1, 32'h0101_0000);
    wr(2'd1, 5'd2, 32'h0101_1101);
    wr(2'd2, 5'd3, 32'h0000_0000);
    wr(2'd3, 5'd4, 32'h0000_1100);

    // Run A: all entries match
    launch();
    chk("A_c1_core_rst",  32'(o_core_rst),  32'd1);
    chk("A_c1_busy",      32'(o_busy),      32'd1);
    go_to(10);
    chk("A_c10_core_rst", 32'(o_core_rst),  32'd1);
    go_to(11);
    chk("A_c11_core_rst", 32'(o_core_rst),  32'd0);
    chk("A_c11_raddr",    32'(o_dbg_raddr), 32'd0);
    go_to(111);
    chk("A_c111_raddr",   32'(o_dbg_raddr), 32'd1);
    go_to(114);
    chk("A_c114_raddr",   32'(o_dbg_raddr), 32'd4);
    chk("A_c114_done",    32'(o_done),      32'd0);
    go_to(115);
    chk("A_c115_done",    32'(o_done),      32'd1);
    chk("A_c115_pass",    32'(o_pass),      32'd1);
    chk("A_c115_busy",    32'(o_busy),      32'd0);
    chk("A_c115_raddr",   32'(o_dbg_raddr), 32'd0);
    chk("A_c115_core_rst",32'(o_core_rst),  32'd0);
    go_to(118);
    chk("A_hold_done",    32'(o_done),      32'd1);

    // Run B: restart from DONE; start and exp_we mid-run are ignored
    launch();
    chk("B_c1_done",      32'(o_done),      32'd0);
    chk("B_c1_pass",      32'(o_pass),      32'd0);
    chk("B_c1_busy",      32'(o_busy),      32'd1);
    go_to(50);
    i_start    = 1'b1;
    i_exp_we   = 1'b1;
    i_exp_idx  = 2'd0;
    i_exp_addr = 5'd5;
    i_exp_data = 32'h1234_5678;
    tick();
    i_start  = 1'b0;
    i_exp_we = 1'b0;
    chk("B_c51_core_rst", 32'(o_core_rst),  32'd0);
    go_to(111);
    chk("B_c111_raddr",   32'(o_dbg_raddr), 32'd1);
    go_to(114);
    chk("B_c114_done",    32'(o_done),      32'd0);
    go_to(115);
    chk("B_c115_done",    32'(o_done),      32'd1);
    chk("B_c115_pass",    32'(o_pass),      32'd1);

    // Run C: write entry 2 together with start; mismatch at entry 2
    i_exp_we   = 1'b1;
    i_exp_idx  = 2'd2;
    i_exp_addr = 5'd3;
    i_exp_data = 32'hDEAD_BEEF;
    launch();
    go_to(111);
    chk("C_c111_raddr",   32'(o_dbg_raddr), 32'd1);
    go_to(112);
    chk("C_c112_raddr",   32'(o_dbg_raddr), 32'd2);
    go_to(113);
    chk("C_c113_raddr",   32'(o_dbg_raddr), 32'd3);
    chk("C_c113_done",    32'(o_done),      32'd0);
    go_to(114);
    chk("C_c114_done",    32'(o_done),      32'd1);
    chk("C_c114_pass",    32'(o_pass),      32'd0);
    chk("C_c114_fail_idx",32'(o_fail_idx),  32'd2);
    chk("C_c114_fail_dat",o_fail_data,      32'h0000_0000);
    chk("C_c114_raddr",   32'(o_dbg_raddr), 32'd0);
    go_to(116);
    chk("C_c116_raddr",   32'(o_dbg_raddr), 32'd0);

    // Run D: restore entry 2, break entry 0; fail at first entry
    wr(2'd2, 5'd3, 32'h0000_0000);
    i_exp_we   = 1'b1;
    i_exp_idx  = 2'd0;
    i_exp_addr = 5'd1;
    i_exp_data = 32'h0000_0000;
    launch();
    chk("D_c1_fail_idx",  32'(o_fail_idx),  32'd0);
    go_to(111);
    chk("D_c111_done",    32'(o_done),      32'd0);
    go_to(112);
    chk("D_c112_done",    32'(o_done),      32'd1);
    chk("D_c112_pass",    32'(o_pass),      32'd0);
    chk("D_c112_fail_idx",32'(o_fail_idx),  32'd0);
    chk("D_c112_fail_dat",o_fail_data,      32'h0101_0000);

    // Run E: rst mid-run clears everything, then an empty-table run passes
    launch();
    go_to(60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E_rst_core_rst", 32'(o_core_rst),  32'd1);
    chk("E_rst_busy",     32'(o_busy),      32'd0);
    chk("E_rst_done",     32'(o_done),      32'd0);
    launch();
    go_to(111);
    chk("E_c111_raddr",   32'(o_dbg_raddr), 32'd0);
    go_to(115);
    chk("E_c115_done",    32'(o_done),      32'd1);
    chk("E_c115_pass",    32'(o_pass),      32'd1);

`ifdef TEST_SEQ_HALT_EN
    // Run F: early halt at cycle 40
    launch();
    go_to(40);
    i_halt_req = 1'b1;
    tick();
    i_halt_req = 1'b0;
    chk("F_c41_busy",     32'(o_busy),      32'd1);
    chk("F_c41_run_count",32'(o_run_count), 32'd30);
    go_to(44);
    chk("F_c44_done",     32'(o_done),      32'd0);
    go_to(45);
    chk("F_c45_done",     32'(o_done),      32'd1);
    chk("F_c45_pass",     32'(o_pass),      32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
